// File: rtl/seq_dtree_classifier.sv
// Sequential decision-tree classifier: walks a register-held node table,
// evaluating one comparison node per clock between a valid/ready feature
// input and a valid/ready class output.
// Optional macro DTREE_SHIFT_CMP_EN: non-leaf compares use
// (feat >> shift) <= thr instead of the full-width feat <= thr.
module seq_dtree_classifier #(
    parameter int N_FEAT    = 8,
    parameter int FEAT_W    = 8,
    parameter int N_NODES   = 32,
    parameter int CLASS_W   = 5,
    parameter int MAX_STEPS = 16,
    localparam int NODE_AW  = $clog2(N_NODES),
    localparam int IDX_W    = $clog2(N_FEAT),
    localparam int NODE_W   = 1 + IDX_W + FEAT_W + 2*NODE_AW + 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [N_FEAT*FEAT_W-1:0] in_feat,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CLASS_W-1:0]       out_class,
    output logic                     out_err,
    input  logic                     cfg_we,
    input  logic [NODE_AW-1:0]       cfg_addr,
    input  logic [NODE_W-1:0]        cfg_data
);

    localparam int STEP_W = (MAX_STEPS > 1) ? $clog2(MAX_STEPS) : 1;

    typedef enum logic [1:0] {IDLE, EVAL, DONE} state_t;

    state_t                    state, state_nxt;
    logic [NODE_W-1:0]         node_tbl [N_NODES];
    logic [N_FEAT*FEAT_W-1:0]  feat_q;
    logic [NODE_AW-1:0]        cur;
    logic [STEP_W-1:0]         steps;

    logic [NODE_W-1:0]         node;
    logic                      node_leaf;
    logic [IDX_W-1:0]          node_fidx;
    logic [FEAT_W-1:0]         node_thr;
    logic [NODE_AW-1:0]        node_left;
    logic [NODE_AW-1:0]        node_right;
    logic [2:0]                node_shift;
    logic [FEAT_W-1:0]         feat_sel;
    logic [FEAT_W-1:0]         cmp_val;
    logic                      go_left;
    logic                      last_step;

    // Current node word, read combinationally; indices past the table read as an all-zero node.
    always_comb begin
        node = '0;
        if (int'(cur) < N_NODES) node = node_tbl[cur];
    end

    assign {node_leaf, node_fidx, node_thr, node_left, node_right, node_shift} = node;

    // Select the addressed feature; out-of-range indices fall back to feature 0.
    always_comb begin
        // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
        feat_sel = feat_q[FEAT_W-1:0];
        for (int i = 1; i < N_FEAT; i++) begin
            if (int'(node_fidx) == i) feat_sel = feat_q[i*FEAT_W +: FEAT_W];
        end
    end

`ifdef DTREE_SHIFT_CMP_EN
    logic [2:0] shift_sat;

    // Coarse compare: drop the low shift bits of the feature, saturating the shift at FEAT_W-1.
    always_comb begin
        shift_sat = node_shift;
        if (int'(node_shift) > FEAT_W - 1) shift_sat = 3'(FEAT_W - 1);
        cmp_val = feat_sel >> shift_sat;
    end
`else
    logic unused_shift;

    // Full-width compare; the shift field is stored but has no effect.
    always_comb begin
        cmp_val      = feat_sel;
        unused_shift = ^node_shift;
    end
`endif

    assign go_left   = (cmp_val <= node_thr);
    assign last_step = (steps == STEP_W'(MAX_STEPS - 1));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic: accept in IDLE, walk nodes in EVAL, hold the result in DONE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)                state_nxt = EVAL;
            EVAL:    if (node_leaf || last_step)  state_nxt = DONE;
            DONE:    if (out_ready)               state_nxt = IDLE;
            default:                              state_nxt = IDLE;
        endcase
    end

    // Handshake outputs decoded from the state.
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // Datapath: latch features on accept, step through nodes, register the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            feat_q    <= '0;
            cur       <= '0;
            steps     <= '0;
            out_class <= '0;
            out_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        feat_q <= in_feat;
                        cur    <= '0;
                        steps  <= '0;
                    end
                end
                EVAL: begin
                    if (node_leaf) begin
                        out_class <= node_thr[CLASS_W-1:0];
                        out_err   <= 1'b0;
                    end else if (last_step) begin
                        out_class <= '0;
                        out_err   <= 1'b1;
                    end else begin
                        cur   <= go_left ? node_left : node_right;
                        steps <= steps + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Node table: writable only while idle so an inference always sees a stable tree.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the table is cleared on reset so an unprogrammed block deterministically ends in out_err.
            for (int i = 0; i < N_NODES; i++) node_tbl[i] <= '0;
        end else if (state == IDLE && cfg_we && int'(cfg_addr) < N_NODES) begin
            node_tbl[cfg_addr] <= cfg_data;
        end
    end

endmodule

// File: tb/tb_seq_dtree_classifier.sv
// Self-checking bench for seq_dtree_classifier: directed scenarios plus random
// tables/vectors checked against a tree-walking reference model.
// Honours DTREE_SHIFT_CMP_EN in the same way as the design.
module tb_seq_dtree_classifier;

    localparam int N_FEAT    = 8;
    localparam int FEAT_W    = 8;
    localparam int N_NODES   = 32;
    localparam int CLASS_W   = 5;
    localparam int MAX_STEPS = 16;
    localparam int NODE_AW   = 5;
    localparam int IDX_W     = 3;
    localparam int NODE_W    = 1 + IDX_W + FEAT_W + 2*NODE_AW + 3;
    localparam int FV_W      = N_FEAT * FEAT_W;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic [FV_W-1:0]    in_feat;
    logic               out_valid;
    logic               out_ready;
    logic [CLASS_W-1:0] out_class;
    logic               out_err;
    logic               cfg_we;
    logic [NODE_AW-1:0] cfg_addr;
    logic [NODE_W-1:0]  cfg_data;

    int checks = 0;
    int errors = 0;

    logic [NODE_W-1:0] ref_tbl [N_NODES];

    seq_dtree_classifier #(
        .N_FEAT(N_FEAT), .FEAT_W(FEAT_W), .N_NODES(N_NODES),
        .CLASS_W(CLASS_W), .MAX_STEPS(MAX_STEPS)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_feat(in_feat),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_class(out_class), .out_err(out_err),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [NODE_W-1:0] mk_node(bit leaf, int fidx, int thr, int l, int r, int sh);
        return {leaf, IDX_W'(fidx), FEAT_W'(thr), NODE_AW'(l), NODE_AW'(r), 3'(sh)};
    endfunction

    function automatic logic [FV_W-1:0] mk_feat(int f2, int f4);
        logic [FV_W-1:0] f;
        f = '0;
        f[2*FEAT_W +: FEAT_W] = FEAT_W'(f2);
        f[4*FEAT_W +: FEAT_W] = FEAT_W'(f4);
        return f;
    endfunction

    // Reference model: walk the tree from node 0 with at most MAX_STEPS visits.
    // cyc is the number of clocks from accept to out_valid (visits made).
    task automatic ref_walk(input logic [FV_W-1:0] f, output int cls, output bit err, output int cyc);
        int cur, fidx, thr, sh, v;
        logic [NODE_W-1:0] w;
        cur = 0;
        for (int s = 0; s < MAX_STEPS; s++) begin
            w    = ref_tbl[cur];
            fidx = int'(w[NODE_W-2 -: IDX_W]);
            thr  = int'(w[NODE_W-2-IDX_W -: FEAT_W]);
            sh   = int'(w[2:0]);
            if (w[NODE_W-1]) begin
                cls = thr % (2 ** CLASS_W);
                err = 1'b0;
                cyc = s + 1;
                return;
            end
            if (fidx >= N_FEAT) fidx = 0;
            v = int'(f[fidx*FEAT_W +: FEAT_W]);
`ifdef DTREE_SHIFT_CMP_EN
            if (sh > FEAT_W - 1) sh = FEAT_W - 1;
            v = v / (2 ** sh);
`endif
            cur = (v <= thr) ? int'(w[2*NODE_AW+2 -: NODE_AW]) : int'(w[NODE_AW+2 -: NODE_AW]);
        end
        cls = 0;
        err = 1'b1;
        cyc = MAX_STEPS;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_feat   = '0;
        out_ready = 1'b0;
        cfg_we    = 1'b0;
        cfg_addr  = '0;
        cfg_data  = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < N_NODES; i++) ref_tbl[i] = '0;
        @(negedge clk);
    endtask

    task automatic write_node(input int addr, input logic [NODE_W-1:0] w);
        @(negedge clk);
        cfg_we   = 1'b1;
        cfg_addr = NODE_AW'(addr);
        cfg_data = w;
        @(posedge clk);
        @(negedge clk);
        cfg_we = 1'b0;
        ref_tbl[addr] = w;
    endtask

    task automatic program_directed();
        write_node(0, mk_node(0, 2, 8'h3F, 1, 2, 0));
        write_node(1, mk_node(1, 0, 7, 0, 0, 0));
        write_node(2, mk_node(0, 4, 8'h80, 3, 4, 0));
        write_node(3, mk_node(1, 0, 17, 0, 0, 0));
        write_node(4, mk_node(1, 0, 1, 0, 0, 0));
    endtask

    // Count clocks after the accept edge until out_valid is seen (bounded). Ends on a negedge.
    task automatic wait_out(output int cyc);
        cyc = 0;
        do begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end while (!out_valid && cyc < 64);
    endtask

    // Present a vector, let it be accepted, scramble in_feat afterwards, return observed result.
    task automatic run_vector(input logic [FV_W-1:0] f, output int cls, output bit err, output int cyc);
        int n;
        @(negedge clk);
        in_feat  = f;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_feat  = {$urandom, $urandom};
        wait_out(cyc);
        cls = int'(out_class);
        err = out_err;
    endtask

    // Complete the output handshake (starts and ends on a negedge).
    task automatic collect();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (out_class !== '0) begin errors++; $display("FAIL reset_out_class: got %0d want 0", out_class); end
        checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL reset_out_err: got %b want 0", out_err); end
    endtask

    task automatic test_empty_table();
        int cls, cyc; bit err;
        run_vector({$urandom, $urandom}, cls, err, cyc);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL empty_err: got %b want 1", err); end
        checks++; if (cls != 0) begin errors++; $display("FAIL empty_class: got %0d want 0", cls); end
        checks++; if (cyc != MAX_STEPS) begin errors++; $display("FAIL empty_latency: got %0d want %0d", cyc, MAX_STEPS); end
        collect();
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++;
            $display("FAIL empty_release: got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid); end
    endtask

    task automatic test_directed();
        int cls, cyc; bit err;
        int f2 [3] = '{8'h20, 8'h40, 8'h40};
        int f4 [3] = '{8'h00, 8'h80, 8'h81};
        int ec [3] = '{7, 17, 1};
        int el [3] = '{2, 3, 3};
        program_directed();
        for (int i = 0; i < 3; i++) begin
            run_vector(mk_feat(f2[i], f4[i]), cls, err, cyc);
            checks++; if (cls != ec[i] || err !== 1'b0) begin errors++;
                $display("FAIL directed_class[%0d]: got %0d/%b want %0d/0", i, cls, err, ec[i]); end
            checks++; if (cyc != el[i]) begin errors++;
                $display("FAIL directed_latency[%0d]: got %0d want %0d", i, cyc, el[i]); end
            collect();
        end
    endtask

    task automatic test_backpressure();
        int cls, cyc; bit err;
        run_vector(mk_feat(8'h20, 0), cls, err, cyc);
        checks++; if (cls != 7) begin errors++; $display("FAIL bp_first_class: got %0d want 7", cls); end
        in_feat  = mk_feat(8'h40, 8'h81);
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            checks++; if (out_valid !== 1'b1 || out_class !== CLASS_W'(7) || in_ready !== 1'b0) begin errors++;
                $display("FAIL bp_hold[%0d]: got valid=%b class=%0d in_ready=%b want 1 7 0", i, out_valid, out_class, in_ready); end
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++;
            $display("FAIL bp_no_same_cycle_accept: got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid); end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_feat  = '0;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_next_accept: got in_ready=%b want 0", in_ready); end
        wait_out(cyc);
        checks++; if (out_class !== CLASS_W'(1) || cyc != 3) begin errors++;
            $display("FAIL bp_next_result: got class=%0d cyc=%0d want 1 3", out_class, cyc); end
        collect();
    endtask

    task automatic test_cfg_lockout();
        int cls, cyc; bit err;
        @(negedge clk);
        in_feat  = mk_feat(8'h20, 0);
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        cfg_we   = 1'b1;
        cfg_addr = NODE_AW'(1);
        cfg_data = mk_node(1, 0, 3, 0, 0, 0);
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        cfg_we = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_class !== CLASS_W'(7)) begin errors++;
            $display("FAIL lockout_current: got valid=%b class=%0d want 1 7", out_valid, out_class); end
        collect();
        run_vector(mk_feat(8'h20, 0), cls, err, cyc);
        checks++; if (cls != 7) begin errors++; $display("FAIL lockout_next: got %0d want 7", cls); end
        collect();
        write_node(1, mk_node(1, 0, 3, 0, 0, 0));
        run_vector(mk_feat(8'h20, 0), cls, err, cyc);
        checks++; if (cls != 3) begin errors++; $display("FAIL idle_rewrite: got %0d want 3", cls); end
        collect();
        @(negedge clk);
        cfg_we   = 1'b1;
        cfg_addr = NODE_AW'(1);
        cfg_data = mk_node(1, 0, 9, 0, 0, 0);
        in_feat  = mk_feat(8'h20, 0);
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cfg_we   = 1'b0;
        in_valid = 1'b0;
        ref_tbl[1] = mk_node(1, 0, 9, 0, 0, 0);
        wait_out(cyc);
        checks++; if (out_class !== CLASS_W'(9) || cyc != 2) begin errors++;
            $display("FAIL cfg_with_accept: got class=%0d cyc=%0d want 9 2", out_class, cyc); end
        collect();
        write_node(1, mk_node(1, 0, 7, 0, 0, 0));
    endtask

    task automatic test_shift();
        int cls, cyc; bit err;
        int exp_lo;
`ifdef DTREE_SHIFT_CMP_EN
        exp_lo = 7;
`else
        exp_lo = 1;
`endif
        write_node(0, mk_node(0, 2, 1, 1, 2, 5));
        run_vector(mk_feat(8'h3F, 8'h81), cls, err, cyc);
        checks++; if (cls != exp_lo) begin errors++; $display("FAIL shift_3f: got %0d want %0d", cls, exp_lo); end
        collect();
        run_vector(mk_feat(8'h40, 8'h81), cls, err, cyc);
        checks++; if (cls != 1) begin errors++; $display("FAIL shift_40: got %0d want 1", cls); end
        collect();
        write_node(0, mk_node(0, 2, 8'h3F, 1, 2, 0));
    endtask

    task automatic test_reset_mid();
        int cls, cyc; bit err;
        @(negedge clk);
        in_feat  = mk_feat(8'h40, 8'h80);
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_class !== '0 || out_err !== 1'b0) begin errors++;
            $display("FAIL reset_mid: got valid=%b ready=%b class=%0d err=%b want 0 1 0 0", out_valid, in_ready, out_class, out_err); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < N_NODES; i++) ref_tbl[i] = '0;
        run_vector(mk_feat(8'h20, 0), cls, err, cyc);
        checks++; if (err !== 1'b1 || cyc != MAX_STEPS) begin errors++;
            $display("FAIL reset_mid_table_cleared: got err=%b cyc=%0d want 1 %0d", err, cyc, MAX_STEPS); end
        collect();
    endtask

    task automatic test_random();
        int cls, cyc, ecls, ecyc, dly; bit err, eerr;
        logic [FV_W-1:0] f;
        for (int t = 0; t < 4; t++) begin
            for (int n = 0; n < N_NODES; n++)
                write_node(n, mk_node($urandom_range(0, 3) == 0, $urandom_range(0, N_FEAT - 1),
                                      $urandom_range(0, 255), $urandom_range(0, N_NODES - 1),
                                      $urandom_range(0, N_NODES - 1), $urandom_range(0, 7)));
            for (int v = 0; v < 20; v++) begin
                f = {$urandom, $urandom};
                ref_walk(f, ecls, eerr, ecyc);
                run_vector(f, cls, err, cyc);
                checks++; if (cls != ecls || err !== eerr || cyc != ecyc) begin errors++;
                    $display("FAIL random[%0d.%0d]: got class=%0d err=%b cyc=%0d want %0d %b %0d",
                             t, v, cls, err, cyc, ecls, eerr, ecyc); end
                dly = $urandom_range(0, 3);
                repeat (dly) @(negedge clk);
                checks++; if (out_valid !== 1'b1 || int'(out_class) != ecls) begin errors++;
                    $display("FAIL random_hold[%0d.%0d]: got valid=%b class=%0d want 1 %0d", t, v, out_valid, out_class, ecls); end
                collect();
            end
        end
    endtask

    initial begin
        test_reset();
        test_empty_table();
        test_directed();
        test_backpressure();
        test_cfg_lockout();
        test_shift();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_dtree_classifier.md
Name: seq_dtree_classifier

Overview:
- Programmable, sequential decision-tree classifier for low-area printed inference.
- Walks a node table held in on-block registers, evaluating one comparison node per clock.
- Serial alternative to the fully unrolled combinational tree: the same block serves any dataset or tree shape by reloading the table.
- Sits between the feature sampling front-end (valid/ready) and the class consumer (valid/ready).

Parameters:
- N_FEAT, 8: number of input features.
- FEAT_W, 8: bits per feature and per threshold.
- N_NODES, 32: node-table depth; NODE_AW = clog2(N_NODES).
- CLASS_W, 5: class label width (must be <= FEAT_W).
- MAX_STEPS, 16: node visits allowed per inference before abort.

Ports:
- clk in 1: clock.
- rst_n in 1: asynchronous active-low reset.
- in_valid in 1: feature vector valid.
- in_ready out 1: block can accept a vector.
- in_feat in N_FEAT*FEAT_W: packed features; feature i at [i*FEAT_W +: FEAT_W].
- out_valid out 1: result valid.
- out_ready in 1: consumer accepts the result.
- out_class out CLASS_W: predicted class.
- out_err out 1: inference aborted (step limit reached).
- cfg_we in 1: node-table write strobe.
- cfg_addr in NODE_AW: node index to write.
- cfg_data in NODE_W: node word, where NODE_W = 1 + IDX_W + FEAT_W + 2*NODE_AW + 3 and IDX_W = clog2(N_FEAT).

Behaviour:
- Node word fields, MSB to LSB: leaf[1], fidx[IDX_W], thr[FEAT_W], left[NODE_AW], right[NODE_AW], shift[3].
- A leaf node's class is thr[CLASS_W-1:0]; its other fields are ignored.
- The root is always node 0.
- Reset:
  - FSM goes to IDLE; every node word is cleared to 0.
  - in_ready=1, out_valid=0, out_class=0, out_err=0; step counter cleared.
  - Reset mid-inference aborts with no result.
- FSM states: IDLE, EVAL, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch in_feat into an internal register, set cur=0, steps=0, go to EVAL.
- EVAL (in_ready=0), one node per cycle, read combinationally from the table:
  - Leaf node: out_class <= class, out_err <= 0, go to DONE.
  - Non-leaf node: cur <= (feat[fidx] <= thr) ? left : right; steps <= steps+1. Comparison is unsigned.
  - If steps == MAX_STEPS-1 and the node is non-leaf: out_class <= 0, out_err <= 1, go to DONE.
  - fidx >= N_FEAT reads feature 0.
  - Child index >= N_NODES wraps modulo 2^NODE_AW; an all-zero table therefore loops and ends in out_err.
- DONE:
  - out_valid=1; out_class and out_err held stable until out_ready.
  - On out_valid&&out_ready go to IDLE. in_ready rises the following cycle; there is no same-cycle re-accept.
- Latency: a leaf at depth d (root depth 0) gives out_valid exactly d+1 cycles after the accept edge.
- Configuration port:
  - cfg_we is honoured only in IDLE; the write takes effect at the clock edge.
  - cfg_we in EVAL or DONE is dropped silently; the latched features and the tree in use stay unchanged.
  - cfg_we and in_valid together in IDLE: both take effect, and the accepted vector sees the newly written node.
- Latched features are unaffected by in_feat changes after accept.

Optional Feature:
- Macro: DTREE_SHIFT_CMP_EN.
- Defined: a non-leaf compare uses (feat[fidx] >> shift) <= thr, so the node tests only the top FEAT_W-shift bits. This matches coarse-precision thresholds in pruned trees; shift values above FEAT_W-1 saturate at FEAT_W-1.
- Undefined: the shift field is stored but ignored; the compare is full-width feat[fidx] <= thr.

Test Plan:
- Program node0 {nonleaf, fidx2, thr 0x3F, L1, R2}, node1 {leaf, class 7}, node2 {nonleaf, fidx4, thr 0x80, L3, R4}, node3 {leaf 17}, node4 {leaf 1}.
  - Send f2=0x20 -> out_valid 2 cycles after accept, out_class=7, out_err=0.
- Same table; f2=0x40, f4=0x80 -> out_class=17 after 3 cycles. f4=0x81 -> out_class=1 after 3 cycles.
- Hold out_ready=0 for 5 cycles after a result -> out_valid and out_class stable, in_ready=0, a new in_valid is not accepted. Raise out_ready -> IDLE, and the next vector is accepted one cycle later.
- Reset, then send any vector without programming -> out_err=1, out_class=0, out_valid asserted exactly MAX_STEPS (16) cycles after accept.
- During EVAL, write node1 to {leaf, class 3} -> write ignored; the current and next inference with f2=0x20 still give 7. Rewrite in IDLE -> result is 3.
- With DTREE_SHIFT_CMP_EN defined: node0 shift=5, thr=1; f2=0x3F -> left (class 7), f2=0x40 -> right. Without the macro: f2=0x3F -> right.
